rv32i_wb_stage: RTL
===================

Name: rv32i_wb_stage

Overview:
Writeback stage of the 5-stage RV32I pipeline, directly downstream of the memory stage. Selects writeback data from the memory, IO or ALU source and aligns and sign-extends load data. Drives the register-file write port and the WB-stage forwarding bus, each through one register stage. Also owns the retired-instruction counter and a RUN/HALT/FAULT state machine (ebreak halt, misaligned-load fault).

Parameters:
CNT_WIDTH, 64, width of retired-instruction counter instret
HALT_ON_MISALIGN, 1, 1: misaligned load enters FAULT; 0: flag only, write suppressed, keep running

Ports:
clk  input  1  system clock
reset  input  1  synchronous reset, active-high
pc_in  input  32  PC from memory stage
iw_in  input  32  instruction word from memory stage; 0 = bubble
alu_in  input  32  ALU result / effective address from memory stage
wb_en_in  input  1  writeback enable from memory stage
wb_reg_in  input  5  destination register from memory stage
src_sel_in  input  2  0 = memory, 1 = IO, 2 = ALU, 3 = reserved (treated as ALU)
memif_rdata  input  32  raw RAM read word (bank-aligned, unshifted)
io_rdata  input  32  IO read word
regif_we  output  1  register-file write enable
regif_waddr  output  5  register-file write address
regif_wdata  output  32  register-file write data
df_wb_enable  output  1  forwarding: WB-stage write valid
df_wb_reg  output  5  forwarding: WB-stage destination
df_wb_data  output  32  forwarding: WB-stage data
instret  output  CNT_WIDTH  retired-instruction count
halted  output  1  state == HALT
fault  output  1  state == FAULT
fault_pc  output  32  PC of the faulting load

Behaviour:
- Reset (synchronous, clk edge with reset=1): all outputs 0, state = RUN. Reset overrides every other event, including a halt or fault on the same edge.
- Load format when src_sel_in = 0: funct3 = iw_in[14:12], off = alu_in[1:0].
  - LB(000) and LBU(100): byte memif_rdata[8*off+7 : 8*off], sign- or zero-extended.
  - LH(001) and LHU(101): off must be 0 or 2; halfword memif_rdata[8*off+15 : 8*off], sign- or zero-extended.
  - LW(010): off must be 0; full word.
  - Any other funct3: full word, no error.
- IO source: io_rdata passed unmodified. ALU source: alu_in.
- Misaligned load: src_sel_in = 0, opcode iw_in[6:0] = 0000011, and (LH/LHU with off odd, or LW with off != 0).
- Write qualification: wr = wb_en_in & (wb_reg_in != 0) & ~misaligned & (state == RUN). An x0 destination never writes.
- Latency: exactly 1 cycle. On edge N: regif_we <= wr, regif_waddr <= wb_reg_in, regif_wdata <= selected data. The df_wb_* outputs are combinational copies of the regif_* registers.
- When wr = 0, regif_we = 0; regif_waddr and regif_wdata still update (don't-care).
- Retire: ret = (iw_in != 0) & ~misaligned & (state == RUN). instret += 1 on each ret edge, wrapping modulo 2^CNT_WIDTH.
- RUN -> HALT: iw_in = 32'h00100073 (ebreak) while RUN. The ebreak counts as retired.
- RUN -> FAULT: misaligned load while RUN and HALT_ON_MISALIGN = 1. fault_pc <= pc_in. No retire and no write for that instruction.
- Misaligned load with HALT_ON_MISALIGN = 0: no write, no retire, fault_pc <= pc_in, fault pulses high for 1 cycle, state stays RUN.
- HALT and FAULT are terminal until reset. No writes, instret frozen, inputs ignored. fault_pc holds its value.
- Ebreak and misaligned are mutually exclusive (ebreak is not a load). Priority if both were ever decoded: FAULT.

Test Plan:
1. ALU writeback: wb_en=1, reg=5, src_sel=2, alu=0x1234_5678 -> next cycle regif_we=1, waddr=5, wdata=0x12345678, df_wb_* identical, instret=1.
2. Byte loads: memif_rdata=0x80FF_7F01, iw LB with off=3 -> wdata=0xFFFFFF80. LBU with off=3 -> 0x00000080. LB with off=2 -> 0xFFFFFFFF.
3. Halfword and IO: LH with off=2, rdata=0x8001_0000 -> 0xFFFF8001. LHU -> 0x00008001. src_sel=1, io_rdata=0xDEAD_BEEF -> wdata=0xDEADBEEF.
4. x0 suppression: wb_en=1, reg=0, alu=0xFFFF_FFFF -> regif_we=0; instret still increments. Bubble iw=0 -> no increment.
5. Misaligned: LW with alu=0x0000_1002, pc=0x40 -> regif_we=0, fault=1, fault_pc=0x40, instret unchanged. Later valid ALU ops are not written. Reset -> fault=0, RUN.
6. Halt: ebreak at instret=7 -> instret=8, halted=1. A following ALU op to x3 -> regif_we stays 0. Reset asserted on the same edge as the ebreak -> halted=0, instret=0.

Source files
------------

// File: rtl/rv32i_wb_stage.sv
// rv32i_wb_stage: writeback stage of the 5-stage RV32I pipeline.
// Selects writeback data (memory load, IO or ALU), aligns and sign-extends
// load data, registers the register-file write port (the forwarding bus is a
// combinational copy of it), counts retired instructions and runs the
// RUN/HALT/FAULT state machine.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   pc_in, iw_in, alu_in   PC, instruction word (0 = bubble), ALU result/address
//   wb_en_in, wb_reg_in    writeback enable and destination register
//   src_sel_in             0 = memory, 1 = IO, 2/3 = ALU
//   memif_rdata, io_rdata  raw RAM read word, IO read word
//   regif_*                registered register-file write port
//   df_wb_*                forwarding bus (copy of regif_*)
//   instret                retired-instruction counter
//   halted, fault          state == HALT, state == FAULT (or misalign pulse)
//   fault_pc               PC of the most recent misaligned load
//
// state | meaning
// ------+----------------------------------------------------
// RUN   | normal operation, writes and retires allowed
// HALT  | ebreak retired; frozen until reset
// FAULT | misaligned load seen; frozen until reset
module rv32i_wb_stage #(
  parameter int CNT_WIDTH        = 64,
  parameter bit HALT_ON_MISALIGN = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          pc_in,
  input  logic [31:0]          iw_in,
  input  logic [31:0]          alu_in,
  input  logic                 wb_en_in,
  input  logic [4:0]           wb_reg_in,
  input  logic [1:0]           src_sel_in,
  input  logic [31:0]          memif_rdata,
  input  logic [31:0]          io_rdata,
  output logic                 regif_we,
  output logic [4:0]           regif_waddr,
  output logic [31:0]          regif_wdata,
  output logic                 df_wb_enable,
  output logic [4:0]           df_wb_reg,
  output logic [31:0]          df_wb_data,
  output logic [CNT_WIDTH-1:0] instret,
  output logic                 halted,
  output logic                 fault,
  output logic [31:0]          fault_pc
);

  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [6:0]  OP_LOAD = 7'b0000011;

  typedef enum logic [1:0] {RUN, HALT, FAULT} state_t;

  state_t state, state_next;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [1:0]  off;
  logic [31:0] shifted;
  logic [31:0] load_data;
  logic [31:0] sel_data;
  logic        misaligned;
  logic        wr;
  logic        ret;
  logic        capture_pc;
  logic        pulse_next;
  logic        fault_pulse;

  assign opcode = iw_in[6:0];
  assign funct3 = iw_in[14:12];
  assign off    = alu_in[1:0];

  // Bring the addressed byte/halfword down to bit 0.
  assign shifted = memif_rdata >> {off, 3'b000};

  always_comb begin
    load_data = memif_rdata;
    case (funct3)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_data = {24'b0, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_data = {16'b0, shifted[15:0]};
      default: load_data = memif_rdata;
    endcase
  end

  always_comb begin
    case (src_sel_in)
      2'd0:    sel_data = load_data;
      2'd1:    sel_data = io_rdata;
      default: sel_data = alu_in;
    endcase
  end

  assign misaligned = (src_sel_in == 2'd0) && (opcode == OP_LOAD) &&
                      ((((funct3 == 3'b001) || (funct3 == 3'b101)) && off[0]) ||
                       ((funct3 == 3'b010) && (off != 2'b00)));

  // Next state plus the per-instruction qualifiers, which only apply in RUN.
  always_comb begin
    state_next = state;
    wr         = 1'b0;
    ret        = 1'b0;
    capture_pc = 1'b0;
    pulse_next = 1'b0;
    if (state == RUN) begin
      wr  = wb_en_in && (wb_reg_in != 5'd0) && !misaligned;
      ret = (iw_in != 32'd0) && !misaligned;
      if (misaligned) begin
        capture_pc = 1'b1;
        if (HALT_ON_MISALIGN) state_next = FAULT;
        else                  pulse_next = 1'b1;
      end else if (iw_in == EBREAK) begin
        state_next = HALT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regif_we    <= 1'b0;
      regif_waddr <= 5'd0;
      regif_wdata <= 32'd0;
      instret     <= '0;
      fault_pc    <= 32'd0;
      fault_pulse <= 1'b0;
    end else begin
      regif_we    <= wr;
      regif_waddr <= wb_reg_in;
      regif_wdata <= sel_data;
      fault_pulse <= pulse_next;
      if (ret)        instret  <= instret + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      if (capture_pc) fault_pc <= pc_in;
    end
  end

  assign df_wb_enable = regif_we;
  assign df_wb_reg    = regif_waddr;
  assign df_wb_data   = regif_wdata;

  assign halted = (state == HALT);
  assign fault  = (state == FAULT) || fault_pulse;

endmodule
